// File: rtl/median_sample_pacer.sv
// rtl/median_sample_pacer.sv - buffered fixed-rate sample source for the median filter
// Upstream valid/ready samples are queued, then replayed as one-cycle strobes every SAMPLE_DIV cycles.

module median_sample_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     srst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    count;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (srst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count <= count + LW'(1);
            2'b01:   count <= count - LW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head  = mem[rd_ptr];
   assign level = count;
   assign full  = (count == LW'(DEPTH));
   assign empty = (count == '0);

endmodule

module median_sample_pacer #(
   parameter int DATA_WIDTH   = 16,
   parameter int SAMPLE_DIV   = 10,
   parameter int FIFO_DEPTH   = 16,
   parameter int START_THRESH = 4
) (
   input  logic                          ck100m,
   input  logic                          srst,
   input  logic                          run,
   input  logic                          s_valid,
   input  logic [DATA_WIDTH-1:0]         s_data,
   output logic                          s_ready,
   output logic                          out_enable,
   output logic [DATA_WIDTH-1:0]         out_data,
   output logic [$clog2(FIFO_DEPTH):0]   level,
   output logic                          underrun,
   output logic                          busy
);

   localparam int LW = $clog2(FIFO_DEPTH) + 1;
   localparam int CW = $clog2(SAMPLE_DIV);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRIME  = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CW-1:0]         cnt;
   logic                  boundary;
   logic                  enter_stream;
   logic                  pop;
   logic                  set_underrun;
   logic                  push;
   logic                  fifo_full;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;

   assign s_ready = !fifo_full && !srst;
   assign push    = s_valid && s_ready;
   assign busy    = (state != S_IDLE);

   median_sample_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (ck100m),
      .srst      (srst),
      .push      (push),
      .push_data (s_data),
      .pop       (pop),
      .head      (fifo_head),
      .level     (level),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign boundary = (state == S_STREAM) && (cnt == CW'(SAMPLE_DIV - 1));

   always_ff @(posedge ck100m) begin
      if (srst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Dropping run wins over reaching the threshold so a stop request is never delayed.
   always_comb begin
      state_nxt    = state;
      enter_stream = 1'b0;
      pop          = 1'b0;
      set_underrun = 1'b0;
      case (state)
         S_IDLE: begin
            if (run) begin
               state_nxt = S_PRIME;
            end
         end
         S_PRIME: begin
            if (!run) begin
               state_nxt = S_IDLE;
            end else if (level >= LW'(START_THRESH)) begin
               state_nxt    = S_STREAM;
               enter_stream = 1'b1;
            end
         end
         S_STREAM: begin
            if (boundary) begin
               if (!run) begin
                  state_nxt = S_IDLE;
               end else if (!fifo_empty) begin
                  pop = 1'b1;
               end else begin
                  set_underrun = 1'b1;
               end
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge ck100m) begin
      if (srst || state == S_IDLE || enter_stream) begin
         cnt <= '0;
      end else if (cnt == CW'(SAMPLE_DIV - 1)) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   // The strobe lands on the cycle after the boundary, together with the popped head.
   always_ff @(posedge ck100m) begin
      if (srst) begin
         out_enable <= 1'b0;
         out_data   <= '0;
         underrun   <= 1'b0;
      end else begin
         out_enable <= pop;
         if (pop) begin
            out_data <= fifo_head;
         end
         if (set_underrun) begin
            underrun <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_median_sample_pacer.sv
// tb/tb_median_sample_pacer.sv - randomized and directed bench for median_sample_pacer
// A queue-based reference model tracks slot times as absolute cycle numbers.

module tb_median_sample_pacer;

   localparam int DW     = 16;
   localparam int SD     = 10;
   localparam int DEPTH  = 16;
   localparam int THRESH = 4;
   localparam int LW     = $clog2(DEPTH) + 1;

   logic          ck100m = 1'b0;
   logic          srst = 1'b1;
   logic          run = 1'b0;
   logic          s_valid = 1'b0;
   logic [DW-1:0] s_data = '0;
   logic          s_ready;
   logic          out_enable;
   logic [DW-1:0] out_data;
   logic [LW-1:0] level;
   logic          underrun;
   logic          busy;

   median_sample_pacer #(
      .DATA_WIDTH   (DW),
      .SAMPLE_DIV   (SD),
      .FIFO_DEPTH   (DEPTH),
      .START_THRESH (THRESH)
   ) dut (
      .ck100m     (ck100m),
      .srst       (srst),
      .run        (run),
      .s_valid    (s_valid),
      .s_data     (s_data),
      .s_ready    (s_ready),
      .out_enable (out_enable),
      .out_data   (out_data),
      .level      (level),
      .underrun   (underrun),
      .busy       (busy)
   );

   always #5 ck100m = ~ck100m;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: mode 0 idle, 1 priming, 2 streaming; next_slot is an absolute edge number.
   logic [DW-1:0] mq[$];
   int            m_mode = 0;
   longint        ecyc = 0;
   longint        next_slot = 0;
   bit            m_en = 1'b0;
   logic [DW-1:0] m_data = '0;
   bit            m_und = 1'b0;

   longint        st_t[$];
   logic [DW-1:0] st_v[$];

   always @(posedge ck100m) begin : ref_model
      int pre;
      ecyc++;
      m_en = 1'b0;
      if (srst) begin
         mq.delete();
         m_mode = 0;
         m_data = '0;
         m_und  = 1'b0;
      end else begin
         pre = mq.size();
         if (m_mode == 0) begin
            if (run) m_mode = 1;
         end else if (m_mode == 1) begin
            if (!run) begin
               m_mode = 0;
            end else if (pre >= THRESH) begin
               m_mode    = 2;
               next_slot = ecyc + SD;
            end
         end else if (ecyc == next_slot) begin
            next_slot = next_slot + SD;
            if (!run) begin
               m_mode = 0;
            end else if (pre > 0) begin
               m_data = mq.pop_front();
               m_en   = 1'b1;
            end else begin
               m_und = 1'b1;
            end
         end
         if (s_valid && pre < DEPTH) mq.push_back(s_data);
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, ecyc, obs, exp);
      end
   endtask

   task automatic cyc_step();
      @(posedge ck100m);
      #1;
      check_eq("out_enable", 32'(out_enable), 32'(m_en));
      check_eq("out_data", 32'(out_data), 32'(m_data));
      check_eq("level", 32'(level), 32'(mq.size()));
      check_eq("s_ready", 32'(s_ready), 32'(!srst && mq.size() < DEPTH));
      check_eq("underrun", 32'(underrun), 32'(m_und));
      check_eq("busy", 32'(busy), 32'(m_mode != 0));
      if (out_enable === 1'b1) begin
         st_t.push_back(ecyc);
         st_v.push_back(out_data);
      end
   endtask

   task automatic do_reset(input int n, input bit valid_during);
      srst    = 1'b1;
      run     = 1'b0;
      s_valid = valid_during;
      s_data  = DW'($urandom);
      repeat (n) cyc_step();
      srst    = 1'b0;
      s_valid = 1'b0;
      st_t.delete();
      st_v.delete();
   endtask

   task automatic push_one(input logic [DW-1:0] v);
      s_valid = 1'b1;
      s_data  = v;
      cyc_step();
      s_valid = 1'b0;
   endtask

   initial begin : stimulus
      longint r;
      int accepted;

      // T1 reset with s_valid held high
      do_reset(5, 1'b1);

      // T2 prime/stream, then T5 underrun and recovery
      for (int i = 1; i <= 5; i++) push_one(DW'(i));
      r   = ecyc;
      run = 1'b1;
      repeat (70) cyc_step();
      check_eq("t2_strobes", 32'(st_t.size()), 32'd5);
      if (st_t.size() == 5) begin
         check_eq("t2_first_latency", 32'(st_t[0] - r), 32'(2 + SD));
         for (int i = 0; i < 5; i++) check_eq("t2_value", 32'(st_v[i]), 32'(i + 1));
         for (int i = 1; i < 5; i++) check_eq("t2_spacing", 32'(st_t[i] - st_t[i-1]), 32'(SD));
      end
      check_eq("t5_underrun_set", 32'(underrun), 32'd1);
      push_one(16'h0055);
      repeat (15) cyc_step();
      check_eq("t5_recover_strobes", 32'(st_v.size()), 32'd6);
      if (st_v.size() == 6) check_eq("t5_recover_value", 32'(st_v[5]), 32'h55);
      check_eq("t5_underrun_sticky", 32'(underrun), 32'd1);

      // T3 threshold
      do_reset(2, 1'b0);
      run = 1'b1;
      for (int i = 0; i < 3; i++) push_one(DW'(11 + i));
      repeat (100) cyc_step();
      check_eq("t3_no_strobe", 32'(st_t.size()), 32'd0);
      check_eq("t3_busy", 32'(busy), 32'd1);
      push_one(DW'(14));
      repeat (60) cyc_step();
      check_eq("t3_strobes", 32'(st_v.size()), 32'd4);
      if (st_v.size() == 4)
         for (int i = 0; i < 4; i++) check_eq("t3_value", 32'(st_v[i]), 32'(11 + i));

      // T4 full
      do_reset(2, 1'b0);
      accepted = 0;
      for (int i = 0; i < 20; i++) begin
         s_valid = 1'b1;
         s_data  = DW'(i);
         #0;
         if (s_ready === 1'b1) accepted++;
         cyc_step();
      end
      s_valid = 1'b0;
      check_eq("t4_accepted", 32'(accepted), 32'd16);
      check_eq("t4_level_full", 32'(level), 32'(DEPTH));
      check_eq("t4_ready_full", 32'(s_ready), 32'd0);
      run = 1'b1;
      repeat (16 * SD + 15) cyc_step();
      check_eq("t4_strobes", 32'(st_v.size()), 32'd16);
      if (st_v.size() == 16)
         for (int i = 0; i < 16; i++) check_eq("t4_value", 32'(st_v[i]), 32'(i));
      check_eq("t4_level_drained", 32'(level), 32'd0);

      // T6 stop mid-slot, then reset
      do_reset(2, 1'b0);
      for (int i = 0; i < 8; i++) push_one(DW'(100 + i));
      run = 1'b1;
      repeat (16) cyc_step();
      run = 1'b0;
      repeat (20) cyc_step();
      check_eq("t6_one_strobe", 32'(st_v.size()), 32'd1);
      check_eq("t6_level_kept", 32'(level), 32'd7);
      check_eq("t6_idle", 32'(busy), 32'd0);
      srst = 1'b1;
      cyc_step();
      srst = 1'b0;
      repeat (3) cyc_step();
      check_eq("t6_level_cleared", 32'(level), 32'd0);
      check_eq("t6_no_strobe", 32'(st_v.size()), 32'd1);

      // Randomized traffic: a filling phase, then a starving phase
      do_reset(2, 1'b0);
      run = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         srst    = ($urandom_range(0, 499) == 0);
         if ($urandom_range(0, 149) == 0) run = !run;
         s_valid = (i < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0);
         s_data  = DW'($urandom);
         cyc_step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
